// File: rtl/mmio_regfile_axil_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmio_regfile_axil_if : AXI4-Lite bus bundle for the MMIO regfile   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mmio_regfile_axil_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/mmio_regfile_axil.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmio_regfile_axil : AXI4-Lite register file with RO/pulse slots    |
// | and a camera response FIFO with level IRQ.  Rev 1.0                |
// +--------------------------------------------------------------------+
module mmio_regfile_axil #(
   parameter int                NREGS      = 16,
   parameter logic [31:0]       BASE_ADDR  = 32'h7000_0000,
   parameter logic [NREGS-1:0]  RO_MASK    = 16'h03E0,
   parameter logic [NREGS-1:0]  PULSE_MASK = 16'h0401,
   parameter int                RESP_W     = 18,
   parameter int                RESP_DEPTH = 4,
   parameter int                RESP_IDX   = 11,
   parameter int                STAT_IDX   = 12,
   parameter int                IRQEN_IDX  = 13
) (
   input  wire logic                  fclk,
   input  wire logic                  rst_n,
   mmio_regfile_axil_if.slave         bus,
   output logic [NREGS*32-1:0]        regs_out,
   output logic [NREGS-1:0]           wr_pulse,
   input  wire logic [NREGS*32-1:0]   ro_in,
   input  wire logic [RESP_W-1:0]     resp_data,
   input  wire logic                  resp_valid,
   output logic                       irq
);

   localparam int IDXW = $clog2(NREGS);
   localparam int PTRW = $clog2(RESP_DEPTH);
   localparam int CNTW = PTRW + 1;

   localparam logic [IDXW-1:0] RESP_SLOT  = IDXW'(RESP_IDX);
   localparam logic [IDXW-1:0] STAT_SLOT  = IDXW'(STAT_IDX);
   localparam logic [IDXW-1:0] IRQEN_SLOT = IDXW'(IRQEN_IDX);
   localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(RESP_DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic in_window(input logic [31:2] a);
      return a[31:IDXW+2] == BASE_ADDR[31:IDXW+2];
   endfunction

   // ------------------------------------------------------------------
   // Write channel: AW and W latch independently, commit once both held
   // ------------------------------------------------------------------
   logic             aw_held_q, w_held_q, bvalid_q;
   logic [31:2]      aw_addr_q;
   logic [31:0]      w_data_q;
   logic [3:0]       w_strb_q;
   logic [1:0]       bresp_q;
   logic             aw_hs, w_hs, b_hs, commit, wr_ok;
   logic [IDXW-1:0]  wr_idx;

   assign aw_hs  = bus.awvalid & ~aw_held_q;
   assign w_hs   = bus.wvalid & ~w_held_q;
   assign b_hs   = bvalid_q & bus.bready;
   assign commit = aw_held_q & w_held_q & ~bvalid_q;
   assign wr_idx = aw_addr_q[IDXW+1:2];
   assign wr_ok  = in_window(aw_addr_q) && !RO_MASK[wr_idx];

   assign bus.awready = ~aw_held_q;
   assign bus.wready  = ~w_held_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else if (b_hs) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_addr_q <= bus.awaddr[31:2];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // ------------------------------------------------------------------
   // Register storage
   // ------------------------------------------------------------------
   logic [31:0]      regs_q [NREGS];
   logic [31:0]      regs_d [NREGS];
   logic [NREGS-1:0] wr_pulse_q, wr_pulse_d;

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         // Pulse slots hold the written value only during the strobe cycle
         if (PULSE_MASK[i] && wr_pulse_q[i]) begin
            regs_d[i] = '0;
         end
      end
      if (commit && wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) begin
               regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      wr_pulse_d = '0;
      if (commit && wr_ok) begin
         wr_pulse_d[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         wr_pulse_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wr_pulse_q <= wr_pulse_d;
      end
   end

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs_out
      assign regs_out[32*gi +: 32] = regs_q[gi];
   end

   assign wr_pulse = wr_pulse_q;

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   logic [RESP_W-1:0] fifo_mem_q [RESP_DEPTH];
   logic [PTRW:0]     wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]   fifo_count;
   logic [RESP_W-1:0] fifo_head;
   logic              fifo_nonempty, fifo_full;
   logic              fifo_push, fifo_pop, ovf_set, ovf_clr;
   logic              overflow_q;
   logic              r_hs, pop_pend_q;

   assign fifo_count    = wr_ptr_q - rd_ptr_q;
   assign fifo_nonempty = fifo_count != '0;
   assign fifo_full     = fifo_count == FIFO_FULL;
   assign fifo_head     = fifo_mem_q[rd_ptr_q[PTRW-1:0]];

   // A pop frees a slot in the same cycle, so a push against a full FIFO is
   // accepted whenever a pop coincides with it.
   assign fifo_pop  = r_hs & pop_pend_q;
   assign fifo_push = resp_valid & (~fifo_full | fifo_pop);
   assign ovf_set   = resp_valid & fifo_full & ~fifo_pop;
   assign ovf_clr   = commit & wr_ok & (wr_idx == STAT_SLOT);

   always_ff @(posedge fclk) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q[PTRW-1:0]] <= resp_data;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (ovf_set) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read channel: data captured at AR handshake, held until rready
   // ------------------------------------------------------------------
   logic             rvalid_q;
   logic [31:0]      rdata_q;
   logic [1:0]       rresp_q;
   logic             ar_hs;
   logic [IDXW-1:0]  rd_idx;
   logic [31:0]      rd_word;
   logic [1:0]       rd_resp;
   logic             rd_pop;

   assign ar_hs  = bus.arvalid & ~rvalid_q;
   assign r_hs   = rvalid_q & bus.rready;
   assign rd_idx = bus.araddr[IDXW+1:2];

   assign bus.arready = ~rvalid_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_OKAY;
      rd_pop  = 1'b0;
      if (!in_window(bus.araddr[31:2])) begin
         rd_word = 32'hDEAD_BEEF;
         rd_resp = RESP_SLVERR;
      end else if (rd_idx == RESP_SLOT) begin
         if (fifo_nonempty) begin
            rd_word[31]         = 1'b1;
            rd_word[RESP_W-1:0] = fifo_head;
            rd_pop              = 1'b1;
         end
      end else if (rd_idx == STAT_SLOT) begin
         rd_word[31]         = overflow_q;
         rd_word[CNTW-1:0]   = fifo_count;
      end else if (RO_MASK[rd_idx]) begin
         rd_word = ro_in[{rd_idx, 5'b0} +: 32];
      end else begin
         rd_word = regs_q[rd_idx];
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         pop_pend_q <= 1'b0;
      end else if (ar_hs) begin
         rvalid_q   <= 1'b1;
         rdata_q    <= rd_word;
         rresp_q    <= rd_resp;
         pop_pend_q <= rd_pop;
      end else if (r_hs) begin
         rvalid_q   <= 1'b0;
         pop_pend_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Interrupt
   // ------------------------------------------------------------------
   logic irq_q;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= fifo_nonempty & regs_q[IRQEN_SLOT][0];
      end
   end

   assign irq = irq_q;

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{bus.araddr[1:0], bus.awaddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_regfile_axil.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mmio_regfile_axil : randomized bench with behavioural model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mmio_regfile_axil;

   localparam logic [31:0] BASE   = 32'h7000_0000;
   localparam logic [15:0] RO_M   = 16'h03E0;
   localparam logic [15:0] PULS_M = 16'h0401;

   logic fclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 fclk = ~fclk;

   mmio_regfile_axil_if bus ();
   logic [511:0] regs_out, ro_in;
   logic [15:0]  wr_pulse;
   logic [17:0]  resp_data;
   logic         resp_valid, irq;

   mmio_regfile_axil #(
      .NREGS(16), .BASE_ADDR(BASE), .RO_MASK(RO_M), .PULSE_MASK(PULS_M),
      .RESP_W(18), .RESP_DEPTH(4), .RESP_IDX(11), .STAT_IDX(12), .IRQEN_IDX(13)
   ) dut (
      .fclk(fclk), .rst_n(rst_n), .bus(bus.slave),
      .regs_out(regs_out), .wr_pulse(wr_pulse), .ro_in(ro_in),
      .resp_data(resp_data), .resp_valid(resp_valid), .irq(irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: stored words, response queue, sticky overflow flag
   logic [31:0] m_reg [16];
   logic [17:0] m_q [$];
   bit          m_ovf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int slot_of(input logic [31:0] a);
      logic [31:0] off = a - BASE;
      return (off < 32'd64) ? int'(off >> 2) : -1;
   endfunction

   function automatic void exp_read(input logic [31:0] a, output logic [31:0] d,
                                    output logic [1:0] r, output bit pop);
      int s = slot_of(a);
      d = 32'h0; r = 2'b00; pop = 1'b0;
      if (s < 0) begin
         d = 32'hDEAD_BEEF; r = 2'b10;
      end else if (s == 11) begin
         if (m_q.size() > 0) begin
            d = 32'h8000_0000 | 32'(m_q[0]);
            pop = 1'b1;
         end
      end else if (s == 12) begin
         d = (m_ovf ? 32'h8000_0000 : 32'h0) + 32'(m_q.size());
      end else if (RO_M[s]) begin
         d = ro_in[32*s +: 32];
      end else begin
         d = m_reg[s];
      end
   endfunction

   function automatic logic [31:0] sa(input int s);
      return BASE + 32'(s * 4);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
      int s; bit ok; logic [31:0] mask, nv;
      bit aw_fire, w_fire, aw_done, w_done; int cyc, n;
      s  = slot_of(addr);
      ok = (s >= 0) && (RO_M[s[3:0]] == 1'b0);
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      nv = ok ? ((m_reg[s[3:0]] & ~mask) | (data & mask)) : 32'h0;
      aw_fire = 0; w_fire = 0; aw_done = 0; w_done = 0; cyc = 0;
      while (!(aw_done && w_done)) begin
         @(negedge fclk);
         if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1; aw_fire = 0; end
         if (w_fire)  begin bus.wvalid  = 1'b0; w_done  = 1; w_fire  = 0; end
         if (!aw_done && cyc >= aw_dly) begin bus.awvalid = 1'b1; bus.awaddr = addr; end
         if (!w_done && cyc >= w_dly) begin
            bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
         end
         if (bus.awvalid && bus.awready) aw_fire = 1;
         if (bus.wvalid && bus.wready)   w_fire  = 1;
         cyc++;
         if (cyc > 64) begin
            check("aw_w_timeout", 64'd0, 64'd1);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            return;
         end
      end
      check("ready_held", {bus.awready, bus.wready}, 2'b00);
      @(negedge fclk);
      check("b_latency", bus.bvalid, 1'b1);
      n = 0;
      while (!bus.bvalid && n < 16) begin @(negedge fclk); n++; end
      if (!bus.bvalid) begin
         check("b_timeout", 64'd0, 64'd1);
         return;
      end
      check("bresp", bus.bresp, ok ? 2'b00 : 2'b10);
      check("wr_pulse_on", wr_pulse, ok ? (16'h1 << s) : 16'h0);
      if (ok) check("regs_new", regs_out[32*s +: 32], nv);
      bus.bready = 1'b1;
      @(negedge fclk);
      bus.bready = 1'b0;
      check("bvalid_drop", bus.bvalid, 1'b0);
      check("wr_pulse_off", wr_pulse, 16'h0);
      check("ready_back", {bus.awready, bus.wready}, 2'b11);
      if (ok) begin
         m_reg[s] = PULS_M[s] ? 32'h0 : nv;
         if (s == 12) m_ovf = 1'b0;
         check("regs_settled", regs_out[32*s +: 32], m_reg[s]);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      logic [31:0] ed; logic [1:0] er; bit pop; int n;
      exp_read(addr, ed, er, pop);
      @(negedge fclk);
      bus.arvalid = 1'b1; bus.araddr = addr;
      n = 0;
      while (!bus.arready && n < 20) begin @(negedge fclk); n++; end
      if (!bus.arready) begin
         check("ar_timeout", 64'd0, 64'd1);
         bus.arvalid = 1'b0; data = 32'h0; resp = 2'b11;
         return;
      end
      @(negedge fclk);
      bus.arvalid = 1'b0;
      check("r_latency", bus.rvalid, 1'b1);
      for (int i = 0; i < hold; i++) begin
         @(negedge fclk);
         check("r_hold", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, er, ed});
      end
      bus.rready = 1'b1;
      data = bus.rdata; resp = bus.rresp;
      @(negedge fclk);
      bus.rready = 1'b0;
      check("rdata", data, ed);
      check("rresp", resp, er);
      if (pop) void'(m_q.pop_front());
   endtask

   task automatic push_resp(input logic [17:0] d);
      @(negedge fclk);
      resp_valid = 1'b1; resp_data = d;
      if (m_q.size() < 4) m_q.push_back(d); else m_ovf = 1'b1;
      @(negedge fclk);
      resp_valid = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      @(negedge fclk); @(negedge fclk);
      check({tag, "_irq"}, irq, (m_q.size() > 0) && m_reg[13][0]);
      for (int i = 0; i < 16; i++) check({tag, "_regs"}, regs_out[32*i +: 32], m_reg[i]);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d; logic [1:0] r; logic [31:0] a;
      logic [17:0] p [5];
      int op, s;

      bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
      bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
      resp_valid = 0; resp_data = 0;
      for (int i = 0; i < 16; i++) ro_in[32*i +: 32] = $urandom;
      model_reset();
      repeat (3) @(negedge fclk);
      rst_n = 1'b1;
      @(negedge fclk);

      check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
      check("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
      check("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
      check("rst_pulse_irq", {wr_pulse, irq}, 17'h0);
      check("rst_regs", regs_out[63:0], 64'h0);

      // Strobed write with W trailing AW by three cycles
      axi_write(sa(2), 32'hFFFF_FFFF, 4'hF, 0, 0);
      axi_write(sa(2), 32'h1234_5678, 4'b0011, 0, 3);
      check("tp_slot2", regs_out[95:64], 32'hFFFF_5678);
      axi_read(sa(2), 0, d, r);

      // Pulse slot reads back zero
      axi_write(sa(0), 32'h5, 4'hF, 0, 0);
      axi_read(sa(0), 0, d, r);
      check("tp_pulse_rb", d, 32'h0);

      // Rejected writes and out-of-window read
      axi_write(sa(5), 32'hAAAA_5555, 4'hF, 1, 0);
      axi_write(32'h7100_0000, 32'h1111_2222, 4'hF, 0, 2);
      axi_read(32'h7100_0000, 0, d, r);
      check("tp_oow_rd", {r, d}, {2'b10, 32'hDEAD_BEEF});
      axi_read(sa(5), 0, d, r);
      idle_check("tp_reject");

      // Overflow then drain
      for (int i = 0; i < 5; i++) begin
         p[i] = 18'($urandom);
         push_resp(p[i]);
      end
      axi_read(sa(12), 0, d, r);
      check("tp_stat_full", d, 32'h8000_0004);
      for (int i = 0; i < 4; i++) begin
         axi_read(sa(11), 0, d, r);
         check("tp_pop_order", d, 32'h8000_0000 | 32'(p[i]));
      end
      axi_read(sa(11), 0, d, r);
      check("tp_pop_empty", {r, d}, 34'h0);
      axi_write(sa(12), 32'h0, 4'h0, 0, 0);
      axi_read(sa(12), 0, d, r);
      check("tp_stat_clr", d, 32'h0);

      // IRQ
      axi_write(sa(13), 32'h1, 4'h1, 0, 0);
      push_resp(18'h2A5A5);
      idle_check("irq_on");
      axi_read(sa(11), 0, d, r);
      idle_check("irq_off");
      axi_write(sa(13), 32'h0, 4'h1, 0, 0);
      push_resp(18'h00033);
      idle_check("irq_mask");
      axi_read(sa(11), 0, d, r);

      // Read held off by rready
      axi_read(sa(2), 10, d, r);

      // Write commit and read capture of the same slot in one cycle
      axi_write(sa(3), 32'hCAFE_0001, 4'hF, 0, 0);
      @(negedge fclk);
      bus.awvalid = 1; bus.awaddr = sa(3); bus.wvalid = 1; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
      @(negedge fclk);
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 1; bus.araddr = sa(3);
      @(negedge fclk);
      bus.arvalid = 0;
      check("rw_same_old", {bus.rvalid, bus.rdata}, {1'b1, 32'hCAFE_0001});
      check("rw_same_b", {bus.bvalid, bus.bresp}, 3'b100);
      bus.bready = 1; bus.rready = 1;
      @(negedge fclk);
      bus.bready = 0; bus.rready = 0;
      m_reg[3] = 32'h0BAD_F00D;
      idle_check("rw_same");

      // Push and pop together while full: both happen, no overflow
      for (int i = 0; i < 4; i++) push_resp(18'(i + 18'h100));
      @(negedge fclk);
      bus.arvalid = 1; bus.araddr = sa(11);
      @(negedge fclk);
      bus.arvalid = 0;
      check("full_pp_rd", bus.rdata, 32'h8000_0100);
      bus.rready = 1; resp_valid = 1; resp_data = 18'h3FFFF;
      @(negedge fclk);
      bus.rready = 0; resp_valid = 0;
      void'(m_q.pop_front());
      m_q.push_back(18'h3FFFF);
      axi_read(sa(12), 0, d, r);
      check("full_pp_stat", d, 32'h4);
      for (int i = 0; i < 4; i++) axi_read(sa(11), 0, d, r);

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         s  = $urandom_range(0, 15);
         a  = ($urandom_range(0, 9) == 0) ? BASE + 32'd64 + 32'($urandom_range(0, 4000) * 4)
                                           : sa(s) + 32'($urandom_range(0, 3));
         if (op < 4) begin
            axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
         end else if (op < 7) begin
            if ($urandom_range(0, 2) == 0) a = sa(11);
            axi_read(a, $urandom_range(0, 3), d, r);
         end else begin
            push_resp(18'($urandom));
         end
         idle_check("rand");
      end

      // Reset asserted while a write response is pending
      axi_write(sa(13), 32'h1, 4'hF, 0, 0);
      push_resp(18'h1);
      @(negedge fclk);
      bus.awvalid = 1; bus.awaddr = sa(4); bus.wvalid = 1; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
      @(negedge fclk);
      bus.awvalid = 0; bus.wvalid = 0;
      @(negedge fclk);
      check("rst_mid_pre", bus.bvalid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_bvalid", {bus.bvalid, bus.rvalid}, 2'b00);
      check("rst_mid_regs", regs_out[255:128], 128'h0);
      check("rst_mid_irq", irq, 1'b0);
      model_reset();
      @(negedge fclk);
      rst_n = 1'b1;
      idle_check("post_rst");
      axi_read(sa(12), 0, d, r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
